// File: rtl/data_mem_handler_pkg.sv
// Shared types and funct3 size codes for the data-memory handler and the core's control unit.
package data_mem_handler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal size code for the direction and naturally aligned for that size.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] addr,
                                       input logic is_store);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr[0];
            F3_W:    ok = (addr == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_handler_load_extender.sv
// Moves the addressed byte/half of a memory word down to bit 0 and sign- or zero-extends it.
module load_extender
    import data_mem_handler_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_handler.sv
// Load/store unit between the core and a word-wide data memory with byte enables,
// alignment checking and a bounded wait for the memory acknowledge.
module data_mem_handler
    import data_mem_handler_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] cpu_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] load_value;
    logic [3:0]  store_sel;
    logic [31:0] store_wdata;
    logic        req_store;

    load_extender u_load_extender (
        .word_i   (mem_rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .result_o (load_value)
    );

    always_comb begin
        case (f3_q)
            F3_B: begin
                store_sel   = 4'b0001 << addr_q[1:0];
                store_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                store_sel   = 4'b0011 << addr_q[1:0];
                store_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                store_sel   = 4'b1111;
                store_wdata = wdata_q;
            end
        endcase
    end

    // A simultaneous read and write request is serviced as a store.
    assign req_store = cpu_write;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_read || cpu_write) begin
                    if (access_ok(funct3, cpu_addr[1:0], req_store)) begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        f3_d    = funct3;
                        we_d    = req_store;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = load_value;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_sel   = mem_req ? (we_q ? store_sel : 4'b1111) : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = store_wdata;
    assign cpu_rdata = rdata_q;

endmodule
